// File: rtl/cocotb_package_param_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cocotb_package_param_reader_if
//  Description : Request and response handshake bundle for the package
//                parameter reader.
//                - master : requester / consumer side
//                - slave  : reader block side
//  Signals     : req_valid, req_ready, req_start, req_count   (request)
//                out_valid, out_ready, out_data, out_index,
//                out_last                                      (response)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cocotb_package_param_reader_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_start;
  logic [CNT_W-1:0]  req_count;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  modport master (
    output req_valid, req_start, req_count, out_ready,
    input  req_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  req_valid, req_start, req_count, out_ready,
    output req_ready, out_valid, out_data, out_index, out_last
  );
endinterface
`default_nettype wire

// File: rtl/cocotb_package_param_reader.sv
`default_nettype none
// ============================================================================
//  Module      : cocotb_package_param_reader
//  Description : Streams the cocotb package constants out as 32-bit words.
//                A request names a start index and a word count; the words
//                are returned one per valid/ready handshake.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - request/response bundle (slave modport)
//                err    - one-cycle pulse when a request is rejected
//                busy   - high whenever the FSM is not idle
//  Options     : COCOTB_PKG_READER_CHECKSUM_EN - append an XOR checksum word
//                (out_index = all ones) after the table words.
//  Revision    : 1.0 - initial release
// ============================================================================

package cocotb_package_pkg_1;
  parameter int          five_int    = 5;
  parameter logic [7:0]  eight_logic = 8'd8;
  parameter logic [63:0] long_param  = 64'hFFFF_FFFF_FFFF_FFFF;
endpackage

package cocotb_package_pkg_2;
  parameter int eleven_int = 11;
endpackage

localparam int unit_four_int = 4;

module cocotb_package_param_reader #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 3
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  cocotb_package_param_reader_if.slave bus,
  output      logic                   err,
  output      logic                   busy
);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("cocotb_package_param_reader: DATA_W must be 32");
    end
  endgenerate

  // Widest of the two request fields plus one bit, so start+count never wraps.
  localparam int SUM_W     = ((IDX_W > CNT_W) ? IDX_W : CNT_W) + 1;
  localparam int C_TAB_LEN = 6;

`ifdef COCOTB_PKG_READER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_CKSUM = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1} state_t;
`endif

  state_t             r_state;
  logic               r_req_ready;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [IDX_W-1:0]   r_out_index;
  logic               r_out_last;
  logic               r_err;
  logic               r_busy;
  logic [CNT_W-1:0]   r_remaining;
`ifdef COCOTB_PKG_READER_CHECKSUM_EN
  logic [DATA_W-1:0]  r_xor;
`endif

  logic [SUM_W-1:0]   w_end;
  logic               w_reject;
  logic [IDX_W-1:0]   w_next_index;
  logic               w_out_fire;

  function automatic logic [DATA_W-1:0] table_word(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = '0;
    case (int'(idx))
      0: v = DATA_W'(cocotb_package_pkg_1::five_int);
      1: v = DATA_W'(cocotb_package_pkg_1::eight_logic);
      2: v = DATA_W'(cocotb_package_pkg_1::long_param[31:0]);
      3: v = DATA_W'(cocotb_package_pkg_1::long_param[63:32]);
      4: v = DATA_W'(cocotb_package_pkg_2::eleven_int);
      5: v = DATA_W'(unit_four_int);
      default: v = '0;
    endcase
    return v;
  endfunction

  assign w_end        = SUM_W'(bus.req_start) + SUM_W'(bus.req_count);
  assign w_reject     = (bus.req_count == '0) ||
                        (SUM_W'(bus.req_start) > SUM_W'(C_TAB_LEN - 1)) ||
                        (w_end > SUM_W'(C_TAB_LEN));
  assign w_next_index = r_out_index + IDX_W'(1);
  assign w_out_fire   = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_remaining <= '0;
`ifdef COCOTB_PKG_READER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= S_STREAM;
              r_req_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b1;
              r_out_index <= bus.req_start;
              r_out_data  <= table_word(bus.req_start);
              r_remaining <= bus.req_count;
`ifdef COCOTB_PKG_READER_CHECKSUM_EN
              r_out_last  <= 1'b0;
              r_xor       <= '0;
`else
              r_out_last  <= (bus.req_count == CNT_W'(1));
`endif
            end
          end
        end

        S_STREAM: begin
          if (w_out_fire) begin
`ifdef COCOTB_PKG_READER_CHECKSUM_EN
            r_xor <= r_xor ^ r_out_data;
`endif
            if (r_remaining == CNT_W'(1)) begin
`ifdef COCOTB_PKG_READER_CHECKSUM_EN
              // Checksum covers every table word, including the one just accepted.
              r_state     <= S_CKSUM;
              r_out_data  <= r_xor ^ r_out_data;
              r_out_index <= '1;
              r_out_last  <= 1'b1;
`else
              r_state     <= S_IDLE;
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_index <= '0;
              r_out_last  <= 1'b0;
`endif
            end else begin
              r_out_index <= w_next_index;
              r_out_data  <= table_word(w_next_index);
              r_remaining <= r_remaining - CNT_W'(1);
`ifndef COCOTB_PKG_READER_CHECKSUM_EN
              r_out_last  <= (r_remaining == CNT_W'(2));
`endif
            end
          end
        end

`ifdef COCOTB_PKG_READER_CHECKSUM_EN
        S_CKSUM: begin
          if (w_out_fire) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
          end
        end
`endif

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_last  = r_out_last;
  assign err           = r_err;
  assign busy          = r_busy;

endmodule
`default_nettype wire
